// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants for the multicycle MIPS datapath register bank:
//   - PCSrc encodings driven by the control unit
//   - primary opcodes seen on the OPcode feedback path
//   - bit positions of the instruction fields
//   - a small sign-extension helper for the 16-bit immediate
package mips_pkg;

  // Next-PC select encodings (control PCSrc)
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_HOLD   = 2'b11;

  // Primary opcodes
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // Instruction field bit positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_MSB  = 25;
  localparam int JADDR_LSB  = 0;

  // Sign-extend a 16-bit immediate to a 32-bit word
  function automatic logic [31:0] signExtend16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_datapath_regs_en_reg.sv
// en_reg
// Generic register with asynchronous active-high reset to a programmable
// value and a synchronous load enable. Tie i_en high for a free-running stage.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active high
//   en   - load enable
//   d    - next value
//   q    - registered value
module en_reg #(
  parameter int              W         = 32,
  parameter logic [W-1:0]    RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Load d on enabled edges; reset wins immediately without a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mc_datapath_regs.sv
// mc_datapath_regs
// Register bank of the multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut,
// next-PC selection, instruction field extraction, debug counters and a
// sticky misaligned-PC flag.
// Ports:
//   clk, rst                  - clock (rising edge), async active-high reset
//   pc_write, branch, ir_write, pc_src - control unit strobes
//   zero                      - ALU zero flag for the current cycle
//   alu_result, mem_rdata, rd1, rd2    - datapath inputs
//   pc, instr, mdr, a_q, b_q, alu_out  - architectural registers
//   opcode, rs, rt, rd, funct, imm_sext - fields decoded from instr
//   pc_next, pc_en            - combinational next-PC and PC load enable
//   pc_misaligned             - sticky: a PC with [1:0] != 0 was loaded
//   instr_count, cycle_count  - IR loads and cycles since reset
module mc_datapath_regs
  import mips_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter int               CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_write,
  input  logic                 branch,
  input  logic                 ir_write,
  input  logic [1:0]           pc_src,
  input  logic                 zero,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic [WIDTH-1:0]     mem_rdata,
  input  logic [WIDTH-1:0]     rd1,
  input  logic [WIDTH-1:0]     rd2,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     instr,
  output logic [5:0]           opcode,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [5:0]           funct,
  output logic [WIDTH-1:0]     imm_sext,
  output logic [WIDTH-1:0]     mdr,
  output logic [WIDTH-1:0]     a_q,
  output logic [WIDTH-1:0]     b_q,
  output logic [WIDTH-1:0]     alu_out,
  output logic [WIDTH-1:0]     pc_next,
  output logic                 pc_en,
  output logic                 pc_misaligned,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0]     w_pc;
  logic [WIDTH-1:0]     w_instr;
  logic [WIDTH-1:0]     w_aluOut;
  logic [WIDTH-1:0]     w_pcNext;
  logic [WIDTH-1:0]     w_jumpTarget;
  logic                 w_pcEn;
  logic                 r_pcMisaligned;
  logic [CNT_WIDTH-1:0] r_instrCount;
  logic [CNT_WIDTH-1:0] r_cycleCount;

  // Branch only redirects when the ALU compare says equal
  assign w_pcEn = pc_write | (branch & zero);

  // Jump keeps the current PC region and word-aligns the 26-bit target
  assign w_jumpTarget = {w_pc[31:28], w_instr[JADDR_MSB:JADDR_LSB], 2'b00};

  always_comb begin
    w_pcNext = w_pc;
    unique case (pc_src)
      PC_ALU:    w_pcNext = alu_result;
      PC_ALUOUT: w_pcNext = w_aluOut;
      PC_JUMP:   w_pcNext = w_jumpTarget;
      PC_HOLD:   w_pcNext = w_pc;
      default:   w_pcNext = w_pc;
    endcase
  end

  // PC and IR both sample on the same edge during fetch, so IR captures the
  // word addressed by the old PC
  en_reg #(.W(WIDTH), .RESET_VAL(RESET_PC)) u_pcReg (
    .clk(clk), .rst(rst), .en(w_pcEn), .d(w_pcNext), .q(w_pc)
  );

  en_reg #(.W(WIDTH), .RESET_VAL('0)) u_irReg (
    .clk(clk), .rst(rst), .en(ir_write), .d(mem_rdata), .q(w_instr)
  );

  en_reg #(.W(WIDTH), .RESET_VAL('0)) u_mdrReg (
    .clk(clk), .rst(rst), .en(1'b1), .d(mem_rdata), .q(mdr)
  );

  en_reg #(.W(WIDTH), .RESET_VAL('0)) u_aReg (
    .clk(clk), .rst(rst), .en(1'b1), .d(rd1), .q(a_q)
  );

  en_reg #(.W(WIDTH), .RESET_VAL('0)) u_bReg (
    .clk(clk), .rst(rst), .en(1'b1), .d(rd2), .q(b_q)
  );

  en_reg #(.W(WIDTH), .RESET_VAL('0)) u_aluOutReg (
    .clk(clk), .rst(rst), .en(1'b1), .d(alu_result), .q(w_aluOut)
  );

  // Debug state: the misaligned flag is sticky until reset, and the PC still
  // takes the misaligned value since there is no trap path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcMisaligned <= 1'b0;
      r_instrCount   <= '0;
      r_cycleCount   <= '0;
    end else begin
      r_cycleCount <= r_cycleCount + CNT_ONE;
      if (ir_write) begin
        r_instrCount <= r_instrCount + CNT_ONE;
      end
      if (w_pcEn && (w_pcNext[1:0] != 2'b00)) begin
        r_pcMisaligned <= 1'b1;
      end
    end
  end

  assign pc            = w_pc;
  assign instr         = w_instr;
  assign alu_out       = w_aluOut;
  assign pc_next       = w_pcNext;
  assign pc_en         = w_pcEn;
  assign pc_misaligned = r_pcMisaligned;
  assign instr_count   = r_instrCount;
  assign cycle_count   = r_cycleCount;

  assign opcode   = w_instr[OPCODE_MSB:OPCODE_LSB];
  assign rs       = w_instr[RS_MSB:RS_LSB];
  assign rt       = w_instr[RT_MSB:RT_LSB];
  assign rd       = w_instr[RD_MSB:RD_LSB];
  assign funct    = w_instr[FUNCT_MSB:FUNCT_LSB];
  assign imm_sext = signExtend16(w_instr[IMM_MSB:IMM_LSB]);

endmodule

// File: tb/tb_mc_datapath_regs.sv
// tb_mc_datapath_regs
// Directed self-checking bench for mc_datapath_regs. A second instance with
// 4-bit counters shares all inputs so the counter wrap can be observed.
module tb_mc_datapath_regs;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        branch;
  logic        ir_write;
  logic [1:0]  pc_src;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] rd1;
  logic [31:0] rd2;

  logic [31:0] pc, instr, imm_sext, mdr, a_q, b_q, alu_out, pc_next;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic        pc_en, pc_misaligned;
  logic [31:0] instr_count, cycle_count;

  logic [31:0] pc4, instr4, imm_sext4, mdr4, a_q4, b_q4, alu_out4, pc_next4;
  logic [5:0]  opcode4, funct4;
  logic [4:0]  rs4, rt4, rd4;
  logic        pc_en4, pc_misaligned4;
  logic [3:0]  instr_count4, cycle_count4;

  int checkCount = 0;
  int errorCount = 0;

  mc_datapath_regs dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .branch(branch),
    .ir_write(ir_write), .pc_src(pc_src), .zero(zero),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .rd1(rd1), .rd2(rd2),
    .pc(pc), .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .funct(funct), .imm_sext(imm_sext), .mdr(mdr), .a_q(a_q), .b_q(b_q),
    .alu_out(alu_out), .pc_next(pc_next), .pc_en(pc_en),
    .pc_misaligned(pc_misaligned), .instr_count(instr_count),
    .cycle_count(cycle_count)
  );

  mc_datapath_regs #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .pc_write(pc_write), .branch(branch),
    .ir_write(ir_write), .pc_src(pc_src), .zero(zero),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .rd1(rd1), .rd2(rd2),
    .pc(pc4), .instr(instr4), .opcode(opcode4), .rs(rs4), .rt(rt4), .rd(rd4),
    .funct(funct4), .imm_sext(imm_sext4), .mdr(mdr4), .a_q(a_q4), .b_q(b_q4),
    .alu_out(alu_out4), .pc_next(pc_next4), .pc_en(pc_en4),
    .pc_misaligned(pc_misaligned4), .instr_count(instr_count4),
    .cycle_count(cycle_count4)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic clearControls();
    pc_write = 1'b0;
    branch   = 1'b0;
    ir_write = 1'b0;
    pc_src   = 2'b00;
    zero     = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    alu_result = '0;
    mem_rdata  = '0;
    rd1        = '0;
    rd2        = '0;
    clearControls();

    // Reset state
    #12;
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_instr", instr, 32'h0);
    checkOutput("reset_opcode", {26'b0, opcode}, 32'h0);
    checkOutput("reset_icount", instr_count, 32'h0);
    checkOutput("reset_ccount", cycle_count, 32'h0);
    checkOutput("reset_misal", {31'b0, pc_misaligned}, 32'h0);
    rst = 1'b0;

    // One idle cycle; A and B sample the register file every edge
    rd1 = 32'h1234_5678;
    rd2 = 32'hDEAD_BEEF;
    applyStimulus();
    checkOutput("idle_ccount", cycle_count, 32'd1);
    checkOutput("idle_pc", pc, 32'h0);
    checkOutput("idle_a", a_q, 32'h1234_5678);
    checkOutput("idle_b", b_q, 32'hDEAD_BEEF);

    // Fetch lw $2, 4($1)
    mem_rdata  = 32'h8C22_0004;
    alu_result = 32'd4;
    ir_write   = 1'b1;
    pc_write   = 1'b1;
    pc_src     = 2'b00;
    applyStimulus();
    checkOutput("fetch_instr", instr, 32'h8C22_0004);
    checkOutput("fetch_opcode", {26'b0, opcode}, 32'h23);
    checkOutput("fetch_rs", {27'b0, rs}, 32'd1);
    checkOutput("fetch_rt", {27'b0, rt}, 32'd2);
    checkOutput("fetch_rd", {27'b0, rd}, 32'd0);
    checkOutput("fetch_funct", {26'b0, funct}, 32'd4);
    checkOutput("fetch_imm", imm_sext, 32'd4);
    checkOutput("fetch_pc", pc, 32'd4);
    checkOutput("fetch_icount", instr_count, 32'd1);
    checkOutput("fetch_ccount", cycle_count, 32'd2);
    checkOutput("fetch_mdr", mdr, 32'h8C22_0004);
    checkOutput("fetch_aluout", alu_out, 32'd4);

    // Negative immediate sign extension via a second IR load
    clearControls();
    mem_rdata = 32'h1022_FFF8;
    ir_write  = 1'b1;
    applyStimulus();
    checkOutput("neg_imm", imm_sext, 32'hFFFF_FFF8);
    checkOutput("beq_opcode", {26'b0, opcode}, 32'h04);
    checkOutput("ir_only_pc", pc, 32'd4);

    // Preload ALUOut with a branch target
    clearControls();
    alu_result = 32'h40;
    applyStimulus();
    checkOutput("preload_aluout", alu_out, 32'h40);

    // Branch not taken
    pc_src = 2'b01;
    branch = 1'b1;
    zero   = 1'b0;
    #1;
    checkOutput("bnt_pc_en", {31'b0, pc_en}, 32'h0);
    checkOutput("bnt_pc_next", pc_next, 32'h40);
    applyStimulus();
    checkOutput("bnt_pc", pc, 32'd4);

    // Branch taken
    zero = 1'b1;
    #1;
    checkOutput("bt_pc_en", {31'b0, pc_en}, 32'h1);
    applyStimulus();
    checkOutput("bt_pc", pc, 32'h40);

    // Set up jump: PC = A000_0010, IR = 0800_0100 in one fetch
    clearControls();
    alu_result = 32'hA000_0010;
    mem_rdata  = 32'h0800_0100;
    pc_write   = 1'b1;
    ir_write   = 1'b1;
    applyStimulus();
    checkOutput("jsetup_pc", pc, 32'hA000_0010);
    checkOutput("jsetup_opcode", {26'b0, opcode}, 32'h02);
    ir_write = 1'b0;
    pc_src   = 2'b10;
    applyStimulus();
    checkOutput("jump_pc", pc, 32'hA000_0400);
    checkOutput("jump_misal", {31'b0, pc_misaligned}, 32'h0);
    checkOutput("jump_icount", instr_count, 32'd3);

    // Misaligned load, then hold, then aligned load keeps the flag
    pc_src     = 2'b00;
    alu_result = 32'd6;
    applyStimulus();
    checkOutput("misal_pc", pc, 32'd6);
    checkOutput("misal_flag", {31'b0, pc_misaligned}, 32'h1);
    pc_src     = 2'b11;
    alu_result = 32'd8;
    applyStimulus();
    checkOutput("hold_pc", pc, 32'd6);
    pc_src = 2'b00;
    applyStimulus();
    checkOutput("aligned_pc", pc, 32'd8);
    checkOutput("sticky_flag", {31'b0, pc_misaligned}, 32'h1);

    // Both pc_write and branch high: single update to the same target
    branch     = 1'b1;
    zero       = 1'b1;
    alu_result = 32'h40;
    ir_write   = 1'b1;
    mem_rdata  = 32'h0000_0020;
    for (int i = 0; i < 2; i++) applyStimulus();
    checkOutput("both_pc", pc, 32'h40);
    checkOutput("pre_rst_icount", instr_count, 32'd5);

    // Asynchronous reset between edges
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_pc", pc, 32'h0);
    checkOutput("arst_icount", instr_count, 32'h0);
    checkOutput("arst_misal", {31'b0, pc_misaligned}, 32'h0);
    checkOutput("arst_instr", instr, 32'h0);
    #2;
    rst = 1'b0;
    clearControls();
    alu_result = '0;
    mem_rdata  = '0;
    applyStimulus();
    checkOutput("post_rst_ccount", cycle_count, 32'd1);
    checkOutput("post_rst_pc", pc, 32'h0);

    // 4-bit counter wrap after 16 IR loads
    ir_write = 1'b1;
    for (int i = 0; i < 15; i++) applyStimulus();
    checkOutput("cnt4_15", {28'b0, instr_count4}, 32'd15);
    applyStimulus();
    checkOutput("cnt4_wrap", {28'b0, instr_count4}, 32'd0);
    checkOutput("cnt32_16", instr_count, 32'd16);
    checkOutput("ccount4_wrap", {28'b0, cycle_count4}, 32'd1);
    ir_write = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mc_datapath_regs.md
Name: mc_datapath_regs

Overview:
- Register bank of the multicycle MIPS datapath: PC, IR, MDR, A, B and ALUOut, plus next-PC selection and instruction field extraction.
- Consumes the control unit's PCWrite, Branch, IRWrite and PCSrc each cycle.
- Feeds the opcode field back to the control unit's OPcode input.
- Also holds debug performance counters and a sticky misaligned-PC flag.

Parameters:
- WIDTH, 32, datapath word width; must be 32 for MIPS field layout.
- RESET_PC, 32'h0000_0000, PC value after reset.
- CNT_WIDTH, 32, width of instr_count and cycle_count.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pc_write  in  1  unconditional PC update (control PCWrite)
- branch  in  1  conditional PC update when zero=1 (control Branch)
- ir_write  in  1  IR load enable (control IRWrite)
- pc_src  in  2  next-PC select (control PCSrc)
- zero  in  1  ALU zero flag, current cycle
- alu_result  in  WIDTH  combinational ALU output
- mem_rdata  in  WIDTH  memory read data
- rd1  in  WIDTH  register file port 1 data
- rd2  in  WIDTH  register file port 2 data
- pc  out  WIDTH  program counter
- instr  out  WIDTH  instruction register
- opcode  out  6  instr[31:26], to control unit OPcode
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- funct  out  6  instr[5:0]
- imm_sext  out  WIDTH  sign-extended instr[15:0]
- mdr  out  WIDTH  memory data register
- a_q, b_q  out  WIDTH  registered rd1 and rd2
- alu_out  out  WIDTH  registered alu_result
- pc_next  out  WIDTH  selected next PC (combinational)
- pc_en  out  1  pc_write | (branch & zero) (combinational)
- pc_misaligned  out  1  sticky: a PC with [1:0] != 0 was loaded
- instr_count  out  CNT_WIDTH  count of IR loads
- cycle_count  out  CNT_WIDTH  cycles since reset

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk, rising edge.
- Reset values:
  - pc = RESET_PC.
  - instr, mdr, a_q, b_q, alu_out = 0.
  - pc_misaligned = 0; instr_count = 0; cycle_count = 0.
  - Derived outputs follow combinationally (opcode = 0 after reset).
- pc_next by pc_src:
  - 00: alu_result (PC+4 in fetch state).
  - 01: alu_out (branch target computed in decode).
  - 10: jump target = {pc[31:28], instr[25:0], 2'b00}.
  - 11: pc (hold).
- PC update: on each edge with pc_en=1, pc <= pc_next. pc_write and branch both high is legal: single update, same result.
- IR load: on edge with ir_write=1, instr <= mem_rdata; otherwise hold.
- Fetch cycle (ir_write=1 and pc_write=1 on the same edge):
  - IR captures the word at the old pc.
  - PC takes alu_result.
  - No read-after-write between the two registers.
- Free-running registers: mdr, a_q, b_q, alu_out load every cycle with no enable. This gives 1-cycle latency from mem_rdata, rd1, rd2 and alu_result.
- Field outputs (opcode, rs, rt, rd, funct, imm_sext) are combinational from instr. A new opcode is visible to the control unit the cycle after an IR load.
- imm_sext = {{16{instr[15]}}, instr[15:0]}.
- pc_misaligned:
  - Set on any edge where pc_en=1 and pc_next[1:0] != 0.
  - Cleared only by rst.
  - The PC still loads the misaligned value; there is no trap.
- instr_count: increments on each ir_write edge and wraps modulo 2^CNT_WIDTH.
- cycle_count: increments every edge after reset and wraps modulo 2^CNT_WIDTH.
- Reset mid-operation: every register returns to its reset value immediately. The first post-reset edge behaves as cycle 0 (cycle_count becomes 1).
- pc_src = 11 with pc_en = 1: PC holds; this is not an error.

Decomposition:
- mips_pkg holds:
  - PCSrc localparams PC_ALU=2'b00, PC_ALUOUT=2'b01, PC_JUMP=2'b10, PC_HOLD=2'b11.
  - Opcode localparams: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010, ORI 001101, XORI 001110, SLTI 001010.
  - Field bit-position constants.
- One sub-module, en_reg: parameterised-width async-reset flop with enable and reset value. It is instantiated for pc and instr and, with enable tied high, for mdr, a_q, b_q and alu_out.

Test Plan:
- Reset then 1 cycle idle:
  - pc=0, instr=0, opcode=0, instr_count=0.
  - cycle_count=1 after the first edge.
- Fetch: mem_rdata=32'h8C22_0004, alu_result=4, ir_write=1, pc_write=1, pc_src=00 for 1 edge:
  - instr=8C22_0004, opcode=100011, rs=1, rt=2, imm_sext=4, pc=4, instr_count=1.
- Branch taken vs not:
  - Setup: alu_out preloaded 32'h40, pc_src=01, branch=1, pc_write=0.
  - zero=1 -> pc=40.
  - zero=0 -> pc unchanged and pc_en=0.
- Jump: pc=32'hA000_0010, instr=32'h0800_0100, pc_src=10, pc_write=1:
  - pc=A000_0400.
- Misaligned and hold:
  - pc_src=00, alu_result=6, pc_write=1 -> pc=6 and pc_misaligned=1, which stays 1 after further aligned loads.
  - Then pc_src=11, pc_write=1 -> pc stays 6.
- Async reset mid-run:
  - Assert rst between clock edges with pc=40 and instr_count=5.
  - pc=0, instr_count=0 and pc_misaligned=0 immediately, without waiting for a clock edge.
  - Counter wrap: CNT_WIDTH=4, 16 ir_write edges -> instr_count=0.
